// File: rtl/r2r_dac_stream_ctrl.sv
// Sample FIFO and rate pacer feeding the R2R ladder DAC code bus, with ramp/triangle test modes.
// Optional: define R2R_DAC_LOW_WATER_EN to add the registered fifo_low refill-request output.
module r2r_dac_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         div,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         dac_code,
  output logic                     dac_strobe,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef R2R_DAC_LOW_WATER_EN
  ,
  output logic                     fifo_low
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(DEPTH / 4);
  localparam logic [LVL_W-1:0] PTR_ONE  = LVL_W'(1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [WIDTH-1:0] CODE_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CODE_MAX = '1;

  typedef enum logic [1:0] {
    M_HOLD   = 2'd0,
    M_STREAM = 2'd1,
    M_RAMP   = 2'd2,
    M_TRI    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [DIV_W-1:0] count;
  dir_e             dir;
  mode_e            prev_mode;
  mode_e            mode_cur;
  logic             mode_change;
  logic             tick;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    mode_cur    = mode_e'(mode);
    wr_idx      = wr_ptr[PTR_W-1:0];
    rd_idx      = rd_ptr[PTR_W-1:0];
    fifo_level  = wr_ptr - rd_ptr;
    in_ready    = (fifo_level != LVL_FULL);
    mode_change = (mode_cur != prev_mode);
    tick        = ena && !mode_change && (count == div);
    do_push     = in_valid && in_ready;
    do_pop      = tick && (mode_cur == M_STREAM) && (fifo_level != '0);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dir        <= DIR_UP;
      prev_mode  <= M_HOLD;
      dac_code   <= '0;
      dac_strobe <= 1'b0;
      underrun   <= 1'b0;
`ifdef R2R_DAC_LOW_WATER_EN
      fifo_low   <= 1'b1;
`endif
    end else begin
      prev_mode  <= mode_cur;
      dac_strobe <= 1'b0;

      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;

      // A count already past a lowered div keeps running and wraps naturally.
      if (mode_change) begin
        count <= '0;
      end else if (ena) begin
        count <= (count == div) ? '0 : count + CNT_ONE;
      end

      if (mode_cur == M_HOLD) underrun <= 1'b0;

      if (mode_change) begin
        dir <= DIR_UP;
      end else if (tick) begin
        case (mode_cur)
          M_STREAM: begin
            if (fifo_level != '0) begin
              dac_code   <= mem[rd_idx];
              dac_strobe <= 1'b1;
            end else begin
              underrun <= 1'b1;
            end
          end
          M_RAMP: begin
            dac_code   <= dac_code + CODE_ONE;
            dac_strobe <= 1'b1;
          end
          M_TRI: begin
            dac_strobe <= 1'b1;
            if (dir == DIR_UP) begin
              if (dac_code == CODE_MAX) begin
                dir      <= DIR_DOWN;
                dac_code <= dac_code - CODE_ONE;
              end else begin
                dac_code <= dac_code + CODE_ONE;
              end
            end else begin
              if (dac_code == '0) begin
                dir      <= DIR_UP;
                dac_code <= dac_code + CODE_ONE;
              end else begin
                dac_code <= dac_code - CODE_ONE;
              end
            end
          end
          default: begin
          end
        endcase
      end

`ifdef R2R_DAC_LOW_WATER_EN
      fifo_low <= (fifo_level <= LVL_LOW);
`endif
    end
  end

endmodule

// File: tb/tb_r2r_dac_stream_ctrl.sv
// Scoreboard bench for r2r_dac_stream_ctrl: expected codes are queued by the stimulus and
// popped by a strobe monitor. Checks fifo_low too when R2R_DAC_LOW_WATER_EN is defined.
module tb_r2r_dac_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dac_code;
  logic        dac_strobe;
  logic        underrun;
  logic [4:0]  fifo_level;
`ifdef R2R_DAC_LOW_WATER_EN
  logic        fifo_low;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  r2r_dac_stream_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .mode       (mode),
    .div        (div),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dac_code   (dac_code),
    .dac_strobe (dac_strobe),
    .underrun   (underrun),
    .fifo_level (fifo_level)
`ifdef R2R_DAC_LOW_WATER_EN
    ,
    .fifo_low   (fifo_low)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [15:0] d,
                               input logic v, input logic [7:0] data);
    ena      = e;
    mode     = m;
    div      = d;
    in_valid = v;
    in_data  = data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every strobe must match the next queued code.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dac_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL strobe_unexpected: got code 0x%0h, expected no strobe", dac_code);
      end else begin
        checkOutput("strobe_code", 32'(dac_code), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset held two cycles with in_valid asserted
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b1, 8'hAA);
    step(2);
    checkOutput("rst_code",     32'(dac_code),   32'h0);
    checkOutput("rst_level",    32'(fifo_level), 32'h0);
    checkOutput("rst_ready",    32'(in_ready),   32'h1);
    checkOutput("rst_underrun", 32'(underrun),   32'h0);
    checkOutput("rst_strobe",   32'(dac_strobe), 32'h0);
`ifdef R2R_DAC_LOW_WATER_EN
    checkOutput("rst_fifo_low", 32'(fifo_low),   32'h1);
`endif
    rst_n = 1'b1;

    // STREAM, div=3: three samples at 4-cycle spacing, then underrun
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b1, 8'h10); step(1);
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b1, 8'h20); step(1);
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b1, 8'h30); step(1);
    checkOutput("stream_level3", 32'(fifo_level), 32'h3);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h30);
    applyStimulus(1'b1, 2'd1, 16'd3, 1'b0, 8'h00);
    step(5);
    checkOutput("stream_code1",   32'(dac_code),   32'h10);
    checkOutput("stream_strobe1", 32'(dac_strobe), 32'h1);
    step(1);
    checkOutput("stream_gap",     32'(dac_strobe), 32'h0);
    step(3);
    checkOutput("stream_code2",   32'(dac_code),   32'h20);
    checkOutput("stream_strobe2", 32'(dac_strobe), 32'h1);
    step(4);
    checkOutput("stream_code3",   32'(dac_code),   32'h30);
    checkOutput("stream_no_ur",   32'(underrun),   32'h0);
    step(4);
    checkOutput("underrun_set",   32'(underrun),   32'h1);
    checkOutput("underrun_hold",  32'(dac_code),   32'h30);
    checkOutput("underrun_nostb", 32'(dac_strobe), 32'h0);
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b0, 8'h00);
    step(1);
    checkOutput("underrun_clear", 32'(underrun),   32'h0);

    // Fill to DEPTH in HOLD, 17th push held off
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'd0, 16'd3, 1'b1, 8'(32'h40 + i));
      step(1);
    end
    checkOutput("full_level",   32'(fifo_level), 32'd16);
    checkOutput("full_ready",   32'(in_ready),   32'h0);
    applyStimulus(1'b1, 2'd0, 16'd3, 1'b1, 8'h99);
    step(2);
    checkOutput("full_held",    32'(fifo_level), 32'd16);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h41);
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b1, 8'h99);
    step(2);
    checkOutput("pop_from_full", 32'(fifo_level), 32'd15);
    checkOutput("pop_ready",     32'(in_ready),   32'h1);
    checkOutput("pop_code40",    32'(dac_code),   32'h40);
    step(1);
    checkOutput("pushpop_level", 32'(fifo_level), 32'd15);
    checkOutput("pop_code41",    32'(dac_code),   32'h41);
    applyStimulus(1'b1, 2'd0, 16'd0, 1'b0, 8'h00);
    step(1);
    checkOutput("hold_level",    32'(fifo_level), 32'd15);

    // Reset mid-stream discards contents
    rst_n = 1'b0;
    step(1);
    checkOutput("midrst_level", 32'(fifo_level), 32'h0);
    checkOutput("midrst_code",  32'(dac_code),   32'h0);
    rst_n = 1'b1;

    // RAMP div=0 from 0xFE wraps through 0
    applyStimulus(1'b1, 2'd0, 16'd0, 1'b1, 8'hFE);
    step(1);
    exp_q.push_back(8'hFE);
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b0, 8'h00);
    step(2);
    checkOutput("ramp_seed", 32'(dac_code), 32'hFE);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    applyStimulus(1'b1, 2'd2, 16'd0, 1'b0, 8'h00);
    step(2);
    checkOutput("ramp_ff",   32'(dac_code),   32'hFF);
    checkOutput("ramp_stb1", 32'(dac_strobe), 32'h1);
    step(1);
    checkOutput("ramp_00",   32'(dac_code),   32'h00);
    checkOutput("ramp_stb2", 32'(dac_strobe), 32'h1);
    step(1);
    checkOutput("ramp_01",   32'(dac_code),   32'h01);
    checkOutput("ramp_no_ur", 32'(underrun),  32'h0);

    // TRIANGLE div=0 from 0xFD, with a 5-cycle ena=0 freeze at the peak
    applyStimulus(1'b1, 2'd0, 16'd0, 1'b1, 8'hFD);
    step(1);
    exp_q.push_back(8'hFD);
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b0, 8'h00);
    step(2);
    checkOutput("tri_seed", 32'(dac_code), 32'hFD);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF);
    applyStimulus(1'b1, 2'd3, 16'd0, 1'b0, 8'h00);
    step(2);
    checkOutput("tri_fe_up", 32'(dac_code), 32'hFE);
    step(1);
    checkOutput("tri_ff",    32'(dac_code), 32'hFF);
    applyStimulus(1'b0, 2'd3, 16'd0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1);
      checkOutput("tri_frozen_code",   32'(dac_code),   32'hFF);
      checkOutput("tri_frozen_strobe", 32'(dac_strobe), 32'h0);
    end
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFD);
    applyStimulus(1'b1, 2'd3, 16'd0, 1'b0, 8'h00);
    step(1);
    checkOutput("tri_fe_down", 32'(dac_code), 32'hFE);
    step(1);
    checkOutput("tri_fd_down", 32'(dac_code), 32'hFD);
    applyStimulus(1'b1, 2'd0, 16'd0, 1'b0, 8'h00);
    step(1);

`ifdef R2R_DAC_LOW_WATER_EN
    // Low-water flag: level 5 clears it, draining to 4 sets it a cycle later
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd0, 16'd0, 1'b1, 8'(32'h51 + i));
      step(1);
    end
    applyStimulus(1'b1, 2'd0, 16'd0, 1'b0, 8'h00);
    step(1);
    checkOutput("lw_level5", 32'(fifo_level), 32'h5);
    checkOutput("lw_low0",   32'(fifo_low),   32'h0);
    exp_q.push_back(8'h51);
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b0, 8'h00);
    step(2);
    checkOutput("lw_level4",  32'(fifo_level), 32'h4);
    checkOutput("lw_lag",     32'(fifo_low),   32'h0);
    applyStimulus(1'b1, 2'd0, 16'd0, 1'b0, 8'h00);
    step(1);
    checkOutput("lw_low1",    32'(fifo_low),   32'h1);
`endif

    step(2);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
